// File: rtl/offnariscv_fetch.sv
// Instruction fetch stage: in-order word fetches tagged with their PC, responses buffered
// in a small output FIFO towards decode, redirect flush, misaligned/access-fault exceptions.
module offnariscv_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_resp_valid,
    input  logic [31:0]  imem_resp_data,
    input  logic         imem_resp_err,
    output logic         ifid_tvalid,
    input  logic         ifid_tready,
    // {pc[132:101], untaken_pc[100:69], inst[68:37], int_exc_valid[36], int_exc_code[35:32], id[31:0]}
    output logic [132:0] ifid_tdata
);
    // state         | meaning
    // RUN           | issuing fetches, pushing responses to the FIFO
    // WAIT_REDIRECT | exception beat emitted; idle until the next redirect
    typedef enum logic [0:0] {RUN, WAIT_REDIRECT} state_t;

    localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    state_t         state_q, state_d;
    logic [31:0]    pc_q;
    logic [31:0]    id_q;
    logic [OCW-1:0] outstanding, discard_cnt;
    logic [FCW-1:0] fifo_count;
    logic [FPW-1:0] fifo_rd, fifo_wr;
    logic [TPW-1:0] tag_rd, tag_wr;

    logic [31:0] tag_mem   [MAX_OUTSTANDING];
    logic [31:0] fifo_pc   [FIFO_DEPTH];
    logic [31:0] fifo_inst [FIFO_DEPTH];
    logic        fifo_exc  [FIFO_DEPTH];
    logic [3:0]  fifo_code [FIFO_DEPTH];

    logic        req_hs, resp_keep, mis_push, fifo_push, fifo_pop, credit_ok;
    logic [31:0] push_pc, push_inst;
    logic        push_exc;
    logic [3:0]  push_code;

    function automatic logic [FPW-1:0] fifo_next(input logic [FPW-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        credit_ok = (32'(outstanding) + 32'(fifo_count) < FIFO_DEPTH)
                    && (32'(outstanding) < MAX_OUTSTANDING);
        imem_req_valid = !rst && state_q == RUN && !redirect_valid
                         && pc_q[1:0] == 2'b00 && credit_ok;
        req_hs    = imem_req_valid && imem_req_ready;
        ifid_tvalid = !rst && !redirect_valid && fifo_count != '0;
        fifo_pop  = ifid_tvalid && ifid_tready;
        resp_keep = imem_resp_valid && discard_cnt == '0 && state_q == RUN && !redirect_valid;
        mis_push  = state_q == RUN && pc_q[1:0] != 2'b00 && outstanding == '0
                    && 32'(fifo_count) < FIFO_DEPTH && !redirect_valid;
        fifo_push = resp_keep || mis_push;
        push_pc   = pc_q;
        push_inst = '0;
        push_exc  = 1'b1;
        push_code = 4'd0;
        if (resp_keep) begin
            push_pc   = tag_mem[tag_rd];
            push_inst = imem_resp_data;
            push_exc  = imem_resp_err;
            push_code = imem_resp_err ? 4'd1 : 4'd0;
        end
        if (redirect_valid)
            state_d = RUN;
        else if (state_q == RUN && ((resp_keep && imem_resp_err) || mis_push))
            state_d = WAIT_REDIRECT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            fifo_count  <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                tag_mem[tag_wr] <= pc_q;
                tag_wr          <= tag_next(tag_wr);
            end
            if (imem_resp_valid)
                tag_rd <= tag_next(tag_rd);
            outstanding <= outstanding + OCW'(req_hs) - OCW'(imem_resp_valid);
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                pc_q        <= redirect_pc;
                discard_cnt <= outstanding + OCW'(req_hs) - OCW'(imem_resp_valid);
                fifo_count  <= '0;
                fifo_rd     <= '0;
                fifo_wr     <= '0;
            end else begin
                if (req_hs)
                    pc_q <= pc_q + 32'd4;
                if (imem_resp_valid && discard_cnt != '0)
                    discard_cnt <= discard_cnt - 1'b1;
                else if (resp_keep && imem_resp_err)
                    discard_cnt <= outstanding - 1'b1 + OCW'(req_hs);
                if (fifo_push) begin
                    fifo_pc[fifo_wr]   <= push_pc;
                    fifo_inst[fifo_wr] <= push_inst;
                    fifo_exc[fifo_wr]  <= push_exc;
                    fifo_code[fifo_wr] <= push_code;
                    fifo_wr            <= fifo_next(fifo_wr);
                end
                if (fifo_pop)
                    fifo_rd <= fifo_next(fifo_rd);
                fifo_count <= fifo_count + FCW'(fifo_push) - FCW'(fifo_pop);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst)
            id_q <= '0;
        else if (fifo_pop)
            id_q <= id_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(fifo_push && 32'(fifo_count) == FIFO_DEPTH))
                else $error("fetch output FIFO overflow");
    end
`else
    assign id_q = '0;
`endif

    assign imem_req_addr = pc_q;
    assign ifid_tdata = {fifo_pc[fifo_rd], fifo_pc[fifo_rd] + 32'd4, fifo_inst[fifo_rd],
                         fifo_exc[fifo_rd], fifo_code[fifo_rd], id_q};
endmodule

// File: tb/tb_offnariscv_fetch.sv
// Bench for offnariscv_fetch: latency-programmable memory model, expected beats queued by
// each scenario and checked against every ID handshake.
module tb_offnariscv_fetch;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         imem_req_valid;
    logic         imem_req_ready = 1'b0;
    logic [31:0]  imem_req_addr;
    logic         imem_resp_valid = 1'b0;
    logic [31:0]  imem_resp_data = '0;
    logic         imem_resp_err = 1'b0;
    logic         ifid_tvalid;
    logic         ifid_tready = 1'b0;
    logic [132:0] ifid_tdata;

    offnariscv_fetch dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .ifid_tvalid(ifid_tvalid), .ifid_tready(ifid_tready), .ifid_tdata(ifid_tdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [3:0]  code;
    } beat_t;
    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    beat_t exp_q[$];
    mreq_t mem_q[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, hs_total = 0, pop_total = 0;
    int budget = 0, lat = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFC;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    // Memory: response driven for the cycle that begins at this edge.
    always @(posedge clk) begin
        cyc++;
        imem_req_ready <= !rst && budget > 0;
        if (rst) begin
            mem_q.delete();
            imem_resp_valid <= 1'b0;
            imem_resp_err   <= 1'b0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid <= 1'b1;
            imem_resp_data  <= mem_data(mem_q[0].addr);
            imem_resp_err   <= (mem_q[0].addr == err_addr);
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
            imem_resp_err   <= 1'b0;
        end
    end

    // Mid-cycle sampling of both handshakes; ID beats are scored here.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{cyc + lat, imem_req_addr});
                hs_total++;
                budget--;
            end
            if (ifid_tvalid && ifid_tready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got pc=%h inst=%h exc=%b, required no beat",
                             ifid_tdata[132:101], ifid_tdata[68:37], ifid_tdata[36]);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (ifid_tdata[132:101] !== e.pc || ifid_tdata[100:69] !== e.pc + 32'd4 ||
                        ifid_tdata[68:37] !== e.inst || ifid_tdata[36] !== e.exc ||
                        ifid_tdata[35:32] !== e.code || ifid_tdata[31:0] !== 32'(pop_total)) begin
                        n_fail++;
                        $display("FAIL beat: got pc=%h untaken=%h inst=%h exc=%b code=%0d id=%0d, required pc=%h untaken=%h inst=%h exc=%b code=%0d id=%0d",
                                 ifid_tdata[132:101], ifid_tdata[100:69], ifid_tdata[68:37],
                                 ifid_tdata[36], ifid_tdata[35:32], ifid_tdata[31:0],
                                 e.pc, e.pc + 32'd4, e.inst, e.exc, e.code, pop_total);
                    end
                end
                pop_total++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [31:0] pc, input logic [31:0] inst,
                               input logic exc, input logic [3:0] code);
        exp_q.push_back('{pc, inst, exc, code});
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int t = 0;
        while ((exp_q.size() > 0 || mem_q.size() > 0) && t < limit) begin
            step();
            t++;
        end
        repeat (4) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        budget = 4;
        repeat (3) step();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid);
        end
        n_checks++;
        if (ifid_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tvalid: got %b, required 0", ifid_tvalid);
        end
        n_checks++;
        if (imem_req_addr !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL reset_addr: got %h, required 80000000", imem_req_addr);
        end
        budget = 0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int start = hs_total;
        int t = 0;
        lat = 1;
        ifid_tready = 1'b1;
        for (int i = 0; i < 3; i++)
            expect_beat(32'h8000_0000 + 32'(4 * i), mem_data(32'h8000_0000 + 32'(4 * i)), 1'b0, 4'd0);
        budget = 3;
        while (!imem_resp_valid && t < 20) begin
            step();
            t++;
        end
        step();
        n_checks++;
        if (ifid_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: tvalid got %b one cycle after response, required 1", ifid_tvalid);
        end
        wait_drain("basic", 60);
        n_checks++;
        if (hs_total - start != 3) begin
            n_fail++;
            $display("FAIL basic_req_count: got %0d, required 3", hs_total - start);
        end
    endtask

    task automatic test_backpressure();
        int start_hs, start_pop, held;
        logic [132:0] prev_tdata = '0;
        logic prev_valid = 1'b0;
        ifid_tready = 1'b0;
        lat = 1;
        do_redirect(32'h8000_1000);
        start_hs  = hs_total;
        start_pop = pop_total;
        for (int i = 0; i < 6; i++)
            expect_beat(32'h8000_1000 + 32'(4 * i), mem_data(32'h8000_1000 + 32'(4 * i)), 1'b0, 4'd0);
        budget = 6;
        for (int i = 0; i < 10; i++) begin
            step();
            held = (hs_total - start_hs) - (pop_total - start_pop);
            n_checks++;
            if (held > 2) begin
                n_fail++;
                $display("FAIL bp_credit: in-flight+buffered got %0d, required <= 2", held);
            end
            if (held == 2) begin
                n_checks++;
                if (imem_req_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_req_valid: got %b with credit exhausted, required 0", imem_req_valid);
                end
            end
            if (prev_valid && ifid_tvalid) begin
                n_checks++;
                if (ifid_tdata !== prev_tdata) begin
                    n_fail++;
                    $display("FAIL bp_stable: tdata got %h, required %h", ifid_tdata, prev_tdata);
                end
            end
            prev_valid = ifid_tvalid;
            prev_tdata = ifid_tdata;
        end
        ifid_tready = 1'b1;
        wait_drain("bp", 80);
        n_checks++;
        if (hs_total - start_hs != 6) begin
            n_fail++;
            $display("FAIL bp_req_count: got %0d, required 6", hs_total - start_hs);
        end
    endtask

    task automatic test_redirect_inflight();
        int start, t;
        ifid_tready = 1'b1;
        lat = 6;
        do_redirect(32'h8000_0040);
        start = hs_total;
        budget = 2;
        t = 0;
        while (hs_total - start < 2 && t < 20) begin
            step();
            t++;
        end
        n_checks++;
        if (hs_total - start != 2) begin
            n_fail++;
            $display("FAIL redir_inflight_setup: requests in flight got %0d, required 2", hs_total - start);
        end
        do_redirect(32'h8000_0100);
        lat = 1;
        expect_beat(32'h8000_0100, mem_data(32'h8000_0100), 1'b0, 4'd0);
        expect_beat(32'h8000_0104, mem_data(32'h8000_0104), 1'b0, 4'd0);
        budget = 2;
        wait_drain("redir_inflight", 60);
    endtask

    task automatic test_misaligned();
        int start;
        int req_seen = 0;
        do_redirect(32'h8000_0102);
        start = hs_total;
        expect_beat(32'h8000_0102, 32'h0, 1'b1, 4'd0);
        budget = 5;
        wait_drain("misaligned", 20);
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_req_valid) req_seen++;
        end
        n_checks++;
        if (req_seen != 0 || hs_total != start) begin
            n_fail++;
            $display("FAIL misaligned_idle: req_valid cycles %0d, handshakes %0d, required 0 and 0",
                     req_seen, hs_total - start);
        end
        budget = 0;
        step();
    endtask

    task automatic test_access_fault();
        int start;
        int req_seen = 0;
        ifid_tready = 1'b1;
        lat = 3;
        err_addr = 32'h8000_0008;
        do_redirect(32'h8000_0000);
        start = hs_total;
        expect_beat(32'h8000_0000, mem_data(32'h8000_0000), 1'b0, 4'd0);
        expect_beat(32'h8000_0004, mem_data(32'h8000_0004), 1'b0, 4'd0);
        expect_beat(32'h8000_0008, mem_data(32'h8000_0008), 1'b1, 4'd1);
        budget = 10;
        wait_drain("fault", 60);
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_req_valid) req_seen++;
        end
        n_checks++;
        if (req_seen != 0) begin
            n_fail++;
            $display("FAIL fault_idle: req_valid cycles got %0d, required 0", req_seen);
        end
        n_checks++;
        if (hs_total - start != 4) begin
            n_fail++;
            $display("FAIL fault_req_count: got %0d, required 4 (000C in flight at fault)", hs_total - start);
        end
        budget = 0;
        err_addr = 32'hFFFF_FFFC;
        step();
    endtask

    task automatic test_redirect_collision();
        int t = 0;
        ifid_tready = 1'b1;
        lat = 2;
        do_redirect(32'h8000_2000);
        budget = 2;
        while (!imem_resp_valid && t < 20) begin
            step();
            t++;
        end
        n_checks++;
        if (!imem_resp_valid) begin
            n_fail++;
            $display("FAIL collision_setup: response got %b within bound, required 1", imem_resp_valid);
        end
        do_redirect(32'h8000_3000);
        expect_beat(32'h8000_3000, mem_data(32'h8000_3000), 1'b0, 4'd0);
        expect_beat(32'h8000_3004, mem_data(32'h8000_3004), 1'b0, 4'd0);
        budget = 2;
        wait_drain("collision", 60);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_inflight();
        test_misaligned();
        test_access_fault();
        test_redirect_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
